// File: rtl/byte_pack_pkg.sv
// Shared constants and helpers for the byte_pack stream packer.
package byte_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_N  = 64;

  // Low-aligned mask with cnt+1 ones, clipped to n lanes.
  function automatic logic [MAX_N-1:0] keep_mask(input int unsigned cnt, input int unsigned n);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i <= cnt && i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/byte_pack_if.sv
// Byte-in / word-out stream bundle for byte_pack; master is the side that feeds bytes and takes words.
interface byte_pack_if #(parameter int n = 5);
  import byte_pack_pkg::*;

  localparam int nb = n * BYTE_W;

  logic [BYTE_W-1:0] in_tdata;
  logic              in_tvalid;
  logic              in_tlast;
  logic              in_tready;
  logic [nb-1:0]     out_tdata;
  logic [n-1:0]      out_tkeep;
  logic              out_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic [15:0]       pkt_cnt;

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid, pkt_cnt
  );

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid, pkt_cnt
  );

endinterface

// File: rtl/byte_pack.sv
// Packs n consecutive bytes into one word; a short tail word is zero-padded and flagged via out_tkeep.
// Output is a single register stage; ready passes straight through from downstream.
module byte_pack #(
  parameter int n = 5
) (
  input  logic        aclk,
  input  logic        areset,
  byte_pack_if.slave  bus
);
  import byte_pack_pkg::*;

  localparam int nb    = n * BYTE_W;
  localparam int CNT_W = (n > 1) ? $clog2(n) : 1;

  logic [CNT_W-1:0] acc_cnt;
  logic [nb-1:0]    acc_data;
  logic [n-1:0]     acc_keep;

  logic [nb-1:0]    out_data;
  logic [n-1:0]     out_keep;
  logic             out_last;
  logic             out_valid;
  logic [15:0]      pkt_cnt_q;

  logic             ready;
  logic             accept;
  logic             deliver;
  logic             complete;
  logic [nb-1:0]    ins_data;
  logic [n-1:0]     ins_keep;
  logic [n-1:0]     keep_nxt;

  assign ready    = ~areset & (~out_valid | bus.out_tready);
  assign accept   = bus.in_tvalid & ready;
  assign deliver  = out_valid & bus.out_tready;
  assign complete = (acc_cnt == CNT_W'(n - 1)) | bus.in_tlast;
  assign keep_nxt = n'(keep_mask(32'(acc_cnt), n));

  // Accumulator with the incoming byte dropped into lane acc_cnt; lanes above it read as zero.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    ins_data = '0;
    ins_keep = '0;
    for (int i = 0; i < n; i++) begin
      if (i < int'(acc_cnt)) begin
        ins_data[i*BYTE_W +: BYTE_W] = acc_data[i*BYTE_W +: BYTE_W];
        ins_keep[i]                  = acc_keep[i];
      end else if (i == int'(acc_cnt)) begin
        ins_data[i*BYTE_W +: BYTE_W] = bus.in_tdata;
        ins_keep[i]                  = 1'b1;
      end
    end
  end

  // NOTE: reset is synchronous here -- sampled only on the rising edge, never in the sensitivity list.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_cnt   <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (deliver) begin
        out_valid <= 1'b0;
        if (out_last) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      // A load in the same cycle as a deliver overrides the clear of out_valid above.
      if (accept) begin
        if (complete) begin
          out_data  <= ins_data;
          out_keep  <= ins_keep;
          out_last  <= bus.in_tlast;
          out_valid <= 1'b1;
          acc_cnt   <= '0;
          acc_data  <= '0;
          acc_keep  <= '0;
        end else begin
          acc_data  <= ins_data;
          acc_keep  <= keep_nxt;
          acc_cnt   <= acc_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_tready  = ready;
  assign bus.out_tdata  = out_data;
  assign bus.out_tkeep  = out_keep;
  assign bus.out_tlast  = out_last;
  assign bus.out_tvalid = out_valid;
  assign bus.pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_byte_pack.sv
// Self-checking bench for byte_pack: directed and random packets against a packet-to-word reference model.
module tb_byte_pack;

  localparam int N  = 5;
  localparam int NB = N * 8;

  typedef struct {
    logic [NB-1:0] data;
    logic [N-1:0]  keep;
    logic          last;
  } word_t;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  byte_pack_if #(.n(N)) bp ();
  byte_pack #(.n(N)) dut (.aclk(aclk), .areset(areset), .bus(bp.slave));

  byte_pack_if #(.n(1)) b1 ();
  byte_pack #(.n(1)) dut1 (.aclk(aclk), .areset(areset), .bus(b1.slave));

  int            n_checks = 0;
  int            n_errors = 0;
  word_t         expq[$];
  logic [15:0]   exp_pkt  = '0;
  logic          mon_on   = 1'b0;
  int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic [NB-1:0] last_data;
  logic [N-1:0]  last_keep;
  logic          last_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed timeout/unexpected expected completion", tag);
  endtask

  // Reference model: chop the packet into N-byte words, first byte lowest, tail zero-padded.
  task automatic model_packet(input logic [7:0] pkt[$]);
    word_t e;
    int    len = pkt.size();
    for (int w = 0; w * N < len; w++) begin
      e.data = '0;
      e.keep = '0;
      for (int k = 0; k < N; k++) begin
        if (w * N + k < len) begin
          e.data[8*k +: 8] = pkt[w*N + k];
          e.keep[k]        = 1'b1;
        end
      end
      e.last = ((w + 1) * N >= len);
      expq.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, output int stalls);
    bit done = 0;
    bp.in_tdata  = b;
    bp.in_tlast  = last;
    bp.in_tvalid = 1'b1;
    stalls = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge aclk);
      if (bp.in_tready === 1'b1) done = 1;
      else stalls++;
      @(posedge aclk);
      #1;
    end
    bp.in_tvalid = 1'b0;
    bp.in_tlast  = 1'b0;
    if (!done) fail_now("send_byte");
  endtask

  task automatic send_packet(input logic [7:0] pkt[$], output int stalls);
    int s;
    stalls = 0;
    model_packet(pkt);
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i], i == pkt.size() - 1, s);
      stalls += s;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 3000 && expq.size() != 0; c++) @(negedge aclk);
    if (expq.size() != 0) fail_now("drain");
    repeat (2) @(negedge aclk);
  endtask

  // Output ready driver.
  initial begin
    bp.out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       bp.out_tready = 1'b1;
        1:       bp.out_tready = 1'($urandom_range(0, 1));
        default: bp.out_tready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard on every deliver, ready rule, stability under backpressure, packet counter.
  initial begin
    word_t         e;
    logic          prev_stall = 1'b0;
    logic [NB-1:0] pd;
    logic [N-1:0]  pk;
    logic          pl;
    wait (mon_on);
    forever begin
      @(negedge aclk);
      chk("pkt_cnt", 64'(bp.pkt_cnt), 64'(exp_pkt));
      chk("in_tready_rule", 64'(bp.in_tready), 64'(!areset && (!bp.out_tvalid || bp.out_tready)));
      if (prev_stall && !areset) begin
        chk("stable_valid", 64'(bp.out_tvalid), 64'd1);
        chk("stable_data",  64'(bp.out_tdata),  64'(pd));
        chk("stable_keep",  64'(bp.out_tkeep),  64'(pk));
        chk("stable_last",  64'(bp.out_tlast),  64'(pl));
      end
      if (areset) begin
        exp_pkt    = '0;
        prev_stall = 1'b0;
        expq.delete();
      end else begin
        prev_stall = bp.out_tvalid && !bp.out_tready;
        pd = bp.out_tdata;
        pk = bp.out_tkeep;
        pl = bp.out_tlast;
        if (bp.out_tvalid && bp.out_tready) begin
          last_data = bp.out_tdata;
          last_keep = bp.out_tkeep;
          last_last = bp.out_tlast;
          if (expq.size() == 0) begin
            fail_now("unexpected_word");
          end else begin
            e = expq.pop_front();
            chk("word_data", 64'(bp.out_tdata), 64'(e.data));
            chk("word_keep", 64'(bp.out_tkeep), 64'(e.keep));
            chk("word_last", 64'(bp.out_tlast), 64'(e.last));
            if (e.last) exp_pkt = exp_pkt + 16'd1;
          end
        end
      end
    end
  end

  initial begin
    logic [7:0]    pkt[$];
    int            stalls;
    logic [NB-1:0] held;
    bit            seen;

    bp.in_tdata   = '0;
    bp.in_tvalid  = 1'b0;
    bp.in_tlast   = 1'b0;
    b1.in_tdata   = '0;
    b1.in_tvalid  = 1'b0;
    b1.in_tlast   = 1'b0;
    b1.out_tready = 1'b1;

    // Reset values.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_valid", 64'(bp.out_tvalid), 64'd0);
    chk("rst_data",  64'(bp.out_tdata),  64'd0);
    chk("rst_keep",  64'(bp.out_tkeep),  64'd0);
    chk("rst_last",  64'(bp.out_tlast),  64'd0);
    chk("rst_pkt",   64'(bp.pkt_cnt),    64'd0);
    chk("rst_ready", 64'(bp.in_tready),  64'd0);
    @(posedge aclk);
    #1;
    mon_on = 1'b1;
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_rst", 64'(bp.in_tready), 64'd1);
    @(posedge aclk);
    #1;

    // Two full words, no ready gaps.
    pkt.delete();
    for (int i = 1; i <= 10; i++) pkt.push_back(8'(i));
    send_packet(pkt, stalls);
    chk("t1_no_gaps", 64'(stalls), 64'd0);
    drain();
    chk("t1_pkt_cnt", 64'(bp.pkt_cnt), 64'd1);
    chk("t1_data", 64'(last_data), 64'h0A09080706);
    chk("t1_keep", 64'(last_keep), 64'h1F);
    chk("t1_last", 64'(last_last), 64'd1);
    @(posedge aclk);
    #1;

    // Short packet.
    pkt = '{8'hAA, 8'hBB, 8'hCC};
    send_packet(pkt, stalls);
    drain();
    chk("t2_data", 64'(last_data), 64'h0000CCBBAA);
    chk("t2_keep", 64'(last_keep), 64'h07);
    chk("t2_last", 64'(last_last), 64'd1);
    @(posedge aclk);
    #1;

    // Single-byte packet, visible one cycle after accept.
    pkt = '{8'h5A};
    send_packet(pkt, stalls);
    @(negedge aclk);
    chk("t3_valid", 64'(bp.out_tvalid), 64'd1);
    chk("t3_data",  64'(bp.out_tdata),  64'h000000005A);
    chk("t3_keep",  64'(bp.out_tkeep),  64'h01);
    chk("t3_last",  64'(bp.out_tlast),  64'd1);
    drain();
    @(posedge aclk);
    #1;

    // n=1 instance: every byte is its own word.
    for (int k = 0; k < 4; k++) begin
      b1.in_tdata  = 8'hC0 + 8'(k);
      b1.in_tlast  = 1'(k % 2);
      b1.in_tvalid = 1'b1;
      @(posedge aclk);
      #1;
      b1.in_tvalid = 1'b0;
      @(negedge aclk);
      chk("n1_valid", 64'(b1.out_tvalid), 64'd1);
      chk("n1_data",  64'(b1.out_tdata),  64'(8'hC0 + 8'(k)));
      chk("n1_keep",  64'(b1.out_tkeep),  64'd1);
      chk("n1_last",  64'(b1.out_tlast),  64'(k % 2));
      @(posedge aclk);
      #1;
    end
    @(negedge aclk);
    chk("n1_pkt_cnt", 64'(b1.pkt_cnt), 64'd2);
    @(posedge aclk);
    #1;

    // Random packets with random downstream ready.
    rdy_mode = 1;
    for (int p = 0; p < 12; p++) begin
      pkt.delete();
      for (int i = 0; i < int'($urandom_range(1, 13)); i++) pkt.push_back(8'($urandom));
      send_packet(pkt, stalls);
    end
    drain();
    rdy_mode = 0;
    @(posedge aclk);
    #1;

    // Backpressure: pending word held for 7+ cycles while bytes wait.
    rdy_mode = 2;
    @(posedge aclk);
    #1;
    pkt.delete();
    for (int i = 0; i < 8; i++) pkt.push_back(8'h21 + 8'(i));
    fork
      send_packet(pkt, stalls);
      begin
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge aclk);
          if (bp.out_tvalid === 1'b1) seen = 1;
        end
        if (!seen) fail_now("t4_wait_valid");
        held = bp.out_tdata;
        chk("t4_first_word", 64'(held), 64'h2524232221);
        repeat (7) begin
          @(negedge aclk);
          chk("t4_ready_low", 64'(bp.in_tready),  64'd0);
          chk("t4_hold_data", 64'(bp.out_tdata),  64'(held));
        end
        rdy_mode = 0;
      end
    join
    drain();
    @(posedge aclk);
    #1;

    // Reset mid-packet discards accumulated bytes.
    send_byte(8'h77, 1'b0, stalls);
    send_byte(8'h88, 1'b0, stalls);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("t5_no_word", 64'(bp.out_tvalid), 64'd0);
    end
    @(posedge aclk);
    #1;
    pkt = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send_packet(pkt, stalls);
    @(negedge aclk);
    chk("t5_data", 64'(bp.out_tdata), 64'h1514131211);
    chk("t5_keep", 64'(bp.out_tkeep), 64'h1F);
    drain();

    // Packet counter wrap.
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      pkt = '{8'(i)};
      send_packet(pkt, stalls);
    end
    drain();
    chk("t6_before_wrap", 64'(bp.pkt_cnt), 64'hFFFF);
    @(posedge aclk);
    #1;
    pkt = '{8'hEE};
    send_packet(pkt, stalls);
    drain();
    chk("t6_after_wrap", 64'(bp.pkt_cnt), 64'h0000);

    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/byte_pack.md
# byte_pack

Upstream packer for the skid_crd output stage. It accepts a byte stream one byte per cycle with packet boundaries marked by `in_tlast`, and assembles `n` consecutive bytes into one `nb`-bit word. A short final word of a packet is zero-padded and flagged through `out_tkeep`. The output side is an AXI-Stream-style valid/ready master that connects directly to skid_crd's `in_*` ports.

## Interface
- `n`, default 5: bytes per output word; legal range n ≥ 1.
- `nb`, default n*8: output data width. Derived; do not override.
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  reset, synchronous, active-high.
- `in_tdata`  in  8  input byte.
- `in_tvalid`  in  1  input byte valid.
- `in_tlast`  in  1  last byte of packet; qualified by `in_tvalid`.
- `in_tready`  out  1  input ready.
- `out_tdata`  out  nb  packed word; first-accepted byte in bits [7:0].
- `out_tkeep`  out  n  per-byte valid mask; low-aligned and contiguous.
- `out_tlast`  out  1  word holds the last byte of a packet.
- `out_tvalid`  out  1  output word valid.
- `out_tready`  in  1  downstream ready.
- `pkt_cnt`  out  16  count of packets delivered (output handshakes with `out_tlast`=1).

## Operation
- **Handshake definitions:** accept = `in_tvalid & in_tready`; deliver = `out_tvalid & out_tready`.
- **Ready:** `in_tready` = `~out_tvalid | out_tready`. It is combinational from `out_tready` and never depends on `in_tvalid`. While `areset`=1 it is forced to 0.
- **Accumulator state:** lane index `acc_cnt` (0..n-1), data register `acc_data[nb-1:0]`, mask register `acc_keep[n-1:0]`.
- **On accept, the byte completes a word when `acc_cnt`==n-1 or `in_tlast`=1.** In that case:
  - The output registers load `acc_data` with the new byte inserted at lane `acc_cnt`, with all higher lanes set to 0.
  - `out_tkeep` is set to ones in lanes 0..`acc_cnt`.
  - `out_tlast` is set to `in_tlast`.
  - `out_tvalid` is set to 1.
  - The accumulator clears: `acc_cnt`=0, `acc_data`=0, `acc_keep`=0.
- **On accept, otherwise:** the byte is written to lane `acc_cnt` and `acc_cnt` increments.
- **Deliver without a new load:** `out_tvalid` goes to 0. `out_tdata`, `out_tkeep` and `out_tlast` hold their values.
- **Deliver and load in the same cycle:** the new word replaces the old one and `out_tvalid` stays 1.
- **Output stability:** while `out_tvalid`=1 and `out_tready`=0, all `out_*` signals are stable.
- **pkt_cnt:** increments on each deliver with `out_tlast`=1 and wraps from 0xFFFF to 0x0000.
- **n=1:** every accepted byte produces a word with `out_tkeep`=1'b1.
- **`in_tlast` on the n-th byte:** produces a single full word with `out_tlast`=1. No extra empty word is emitted.

## Timing
- **Reset values:**
  - `out_tvalid`=0, `out_tdata`=0, `out_tkeep`=0, `out_tlast`=0, `pkt_cnt`=0.
  - Accumulator cleared.
  - `in_tready`=0 while reset is asserted, then 1 in the first cycle after reset is released.
- **Reset mid-packet:** bytes already accumulated and any pending output word are discarded. The next accepted byte goes to lane 0.
- **Latency:** when a word-completing byte is accepted at edge t, `out_tvalid`=1 is visible after edge t, i.e. one cycle later.
- **Throughput:** with `out_tready` held at 1, one byte is accepted every cycle and one word is delivered every n cycles. There are no bubbles at word or packet boundaries.
- **Backpressure:** `out_tvalid`=1 with `out_tready`=0 forces `in_tready`=0 in the same cycle. There is no internal buffering beyond the accumulator and the output register; skid_crd downstream provides the registered-ready break.

## Structure
- Package `byte_pack_pkg`:
  - `BYTE_W`=8.
  - Function `keep_mask(cnt, n)` returning a low-aligned mask of cnt+1 ones.
- Single module; no sub-module is warranted. The accumulator and output register total roughly 150 lines.

## Test plan
1. **Two full words:** n=5, `out_tready`=1, bytes 0x01..0x0A with `in_tlast` on 0x0A. Required: word 0x0504030201 with keep 0x1F, last 0; then word 0x0A09080706 with keep 0x1F, last 1; `pkt_cnt`=1; no gaps in `in_tready`.
2. **Short packet:** bytes 0xAA, 0xBB, 0xCC with `in_tlast` on 0xCC. Required: word 0x0000CCBBAA, keep 0x07, last 1.
3. **Single-byte packet:** 0x5A with `in_tlast`. Required: word 0x000000005A, keep 0x01, last 1, appearing one cycle after accept.
4. **Backpressure:** hold `out_tready`=0 for 7 cycles while a word is pending. Required: `in_tready`=0, `out_*` stable throughout. After release, the next bytes are packed in order with no loss or duplication.
5. **Reset mid-packet:** assert `areset` after 2 bytes of a packet. Required: no output word; the following packet 0x11..0x15 yields 0x1514131211.
6. **Counter wrap:** send 65536 single-byte packets. Required: `pkt_cnt` reads 0x0000 after the last deliver and 0xFFFF just before it.
